// File: rtl/if_fetch_bht.sv
// Instruction-fetch stage: PC, single-outstanding IMem request, IF->ID latch,
// and a 2-bit-counter branch history table whose MSB rides along as the prediction.
module if_fetch_bht #(
    parameter logic [31:0] RESET_PC  = 32'h00400000,
    parameter int unsigned BHT_IDX_W = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] IMem_Addr_OUT,
    output logic        IMem_Req_OUT,
    input  logic        IMem_Ready_IN,
    input  logic [31:0] IMem_Data_IN,
    input  logic [31:0] Alt_PC_IN,
    input  logic        Request_Alt_PC_IN,
    input  logic        WANT_FREEZE_IN,
    input  logic        BHT_Update_IN,
    input  logic [31:0] BHT_Update_PC_IN,
    input  logic        BHT_Update_Taken_IN,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] Instr1_PC_Plus4_OUT,
    output logic        Branch_prediction_OUT
);

    localparam int unsigned BHT_DEPTH = 2 ** BHT_IDX_W;

    // FETCH: request out; HOLD: word parked while ID is frozen; DRAIN: finish a squashed request
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state, nx_state;
    logic [31:0]            pc, nx_pc;
    logic [31:0]            nx_addr;
    logic                   nx_req;
    logic [31:0]            buf_instr, nx_buf_instr;
    logic                   buf_pred, nx_buf_pred;
    logic [31:0]            nx_instr, nx_instr_pc, nx_instr_pc4;
    logic                   nx_pred;
    logic                   hs;
    logic [31:0]            pc_plus4;
    logic [1:0]             bht [BHT_DEPTH];
    logic [BHT_IDX_W-1:0]   rd_idx, wr_idx;
    logic                   rd_pred;
    logic                   unused_bits;

    assign rd_idx      = IMem_Addr_OUT[BHT_IDX_W+1:2];
    assign wr_idx      = BHT_Update_PC_IN[BHT_IDX_W+1:2];
    assign rd_pred     = bht[rd_idx][1];
    assign pc_plus4    = pc + 32'd4;
    assign hs          = IMem_Req_OUT & IMem_Ready_IN;
    assign unused_bits = ^{BHT_Update_PC_IN[31:BHT_IDX_W+2], BHT_Update_PC_IN[1:0]};

    // Next-state, next-PC, latch and buffer selection
    always_comb begin
        nx_state     = state;
        nx_pc        = pc;
        nx_buf_instr = buf_instr;
        nx_buf_pred  = buf_pred;
        nx_instr     = Instr1_OUT;
        nx_instr_pc  = Instr1_PC_OUT;
        nx_instr_pc4 = Instr1_PC_Plus4_OUT;
        nx_pred      = Branch_prediction_OUT;

        if (Request_Alt_PC_IN) begin
            // redirect beats freeze: squash latch and buffer, finish any open request in DRAIN
            nx_instr     = '0;
            nx_instr_pc  = '0;
            nx_instr_pc4 = '0;
            nx_pred      = 1'b0;
            nx_buf_instr = '0;
            nx_buf_pred  = 1'b0;
            nx_pc        = Alt_PC_IN;
            nx_state     = (!IMem_Req_OUT || hs) ? FETCH : DRAIN;
        end else begin
            case (state)
                FETCH: begin
                    if (WANT_FREEZE_IN) begin
                        if (hs) begin
                            nx_buf_instr = IMem_Data_IN;
                            nx_buf_pred  = rd_pred;
                            nx_state     = HOLD;
                        end
                    end else if (hs) begin
                        nx_instr     = IMem_Data_IN;
                        nx_instr_pc  = pc;
                        nx_instr_pc4 = pc_plus4;
                        nx_pred      = rd_pred;
                        nx_pc        = pc_plus4;
                    end else begin
                        nx_instr     = '0;
                        nx_instr_pc  = '0;
                        nx_instr_pc4 = '0;
                        nx_pred      = 1'b0;
                    end
                end
                HOLD: begin
                    if (!WANT_FREEZE_IN) begin
                        nx_instr     = buf_instr;
                        nx_instr_pc  = pc;
                        nx_instr_pc4 = pc_plus4;
                        nx_pred      = buf_pred;
                        nx_pc        = pc_plus4;
                        nx_state     = FETCH;
                    end
                end
                DRAIN: begin
                    if (!WANT_FREEZE_IN) begin
                        nx_instr     = '0;
                        nx_instr_pc  = '0;
                        nx_instr_pc4 = '0;
                        nx_pred      = 1'b0;
                    end
                    if (hs) begin
                        nx_state = FETCH;
                    end
                end
                default: nx_state = FETCH;
            endcase
        end

        // address only moves when a fresh request is launched; DRAIN keeps the stale one
        nx_req  = (nx_state != HOLD);
        nx_addr = (nx_state == FETCH) ? nx_pc : IMem_Addr_OUT;
    end

    // State, PC, request port and IF->ID latch registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state                 <= FETCH;
            pc                    <= RESET_PC;
            IMem_Addr_OUT         <= RESET_PC;
            IMem_Req_OUT          <= 1'b0;
            buf_instr             <= '0;
            buf_pred              <= 1'b0;
            Instr1_OUT            <= '0;
            Instr1_PC_OUT         <= '0;
            Instr1_PC_Plus4_OUT   <= '0;
            Branch_prediction_OUT <= 1'b0;
        end else begin
            state                 <= nx_state;
            pc                    <= nx_pc;
            IMem_Addr_OUT         <= nx_addr;
            IMem_Req_OUT          <= nx_req;
            buf_instr             <= nx_buf_instr;
            buf_pred              <= nx_buf_pred;
            Instr1_OUT            <= nx_instr;
            Instr1_PC_OUT         <= nx_instr_pc;
            Instr1_PC_Plus4_OUT   <= nx_instr_pc4;
            Branch_prediction_OUT <= nx_pred;
        end
    end

    // BHT training: saturating 2-bit counters, reset to weakly not-taken
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[BHT_IDX_W'(i)] <= 2'b01;
            end
        end else if (BHT_Update_IN) begin
            if (BHT_Update_Taken_IN) begin
                if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'd1;
            end else begin
                if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_bht.sv
// Bench for if_fetch_bht: driver + reference model push expected deliveries,
// an independent monitor pops and compares whenever the IF->ID latch loads.
module tb_if_fetch_bht;

    localparam logic [31:0] RESET_PC = 32'h00400000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IMem_Addr_OUT;
    logic        IMem_Req_OUT;
    logic        IMem_Ready_IN;
    logic [31:0] IMem_Data_IN;
    logic [31:0] Alt_PC_IN;
    logic        Request_Alt_PC_IN;
    logic        WANT_FREEZE_IN;
    logic        BHT_Update_IN;
    logic [31:0] BHT_Update_PC_IN;
    logic        BHT_Update_Taken_IN;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr1_PC_OUT;
    logic [31:0] Instr1_PC_Plus4_OUT;
    logic        Branch_prediction_OUT;

    if_fetch_bht #(.RESET_PC(RESET_PC), .BHT_IDX_W(6)) dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .IMem_Addr_OUT         (IMem_Addr_OUT),
        .IMem_Req_OUT          (IMem_Req_OUT),
        .IMem_Ready_IN         (IMem_Ready_IN),
        .IMem_Data_IN          (IMem_Data_IN),
        .Alt_PC_IN             (Alt_PC_IN),
        .Request_Alt_PC_IN     (Request_Alt_PC_IN),
        .WANT_FREEZE_IN        (WANT_FREEZE_IN),
        .BHT_Update_IN         (BHT_Update_IN),
        .BHT_Update_PC_IN      (BHT_Update_PC_IN),
        .BHT_Update_Taken_IN   (BHT_Update_Taken_IN),
        .Instr1_OUT            (Instr1_OUT),
        .Instr1_PC_OUT         (Instr1_PC_OUT),
        .Instr1_PC_Plus4_OUT   (Instr1_PC_Plus4_OUT),
        .Branch_prediction_OUT (Branch_prediction_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pred;
    } item_t;

    item_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          bhtm[64];
    logic [31:0] fetch_pc;
    bit          discard;
    bit          holding;
    bit          after_rst;

    // instruction memory contents: never zero, so zero always means bubble
    function automatic logic [31:0] memf(input logic [31:0] a);
        return ((a ^ 32'h5A5A0000) * 32'h9E3779B1) | 32'h1;
    endfunction

    function automatic int bidx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3F);
    endfunction

    assign IMem_Data_IN = memf(IMem_Addr_OUT);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        foreach (bhtm[i]) bhtm[i] = 1;
        fetch_pc  = RESET_PC;
        discard   = 1'b0;
        holding   = 1'b0;
        after_rst = 1'b1;
    endtask

    // drive one cycle of inputs and advance the reference model over the coming edge
    task automatic step(input bit rst, input bit rdy, input bit frz, input bit rdr,
                        input logic [31:0] alt, input bit upd, input logic [31:0] upc,
                        input bit utk);
        bit    hs;
        item_t it;
        @(posedge CLK);
        #2;
        RESET               = ~rst;
        IMem_Ready_IN       = rdy;
        WANT_FREEZE_IN      = frz;
        Request_Alt_PC_IN   = rdr;
        Alt_PC_IN           = alt;
        BHT_Update_IN       = upd;
        BHT_Update_PC_IN    = upc;
        BHT_Update_Taken_IN = utk;
        if (rst) begin
            model_reset();
        end else begin
            check("req_level", 32'(IMem_Req_OUT), 32'(!holding && !after_rst));
            after_rst = 1'b0;
            hs = IMem_Req_OUT && rdy;
            if (rdr) begin
                exp_q.delete();
                discard  = IMem_Req_OUT && !rdy;
                holding  = 1'b0;
                fetch_pc = alt;
            end else if (hs && discard) begin
                discard = 1'b0;
            end else if (hs) begin
                check("fetch_addr", IMem_Addr_OUT, fetch_pc);
                it.instr = memf(fetch_pc);
                it.pc    = fetch_pc;
                it.pc4   = fetch_pc + 32'd4;
                it.pred  = (bhtm[bidx(fetch_pc)] >= 2);
                exp_q.push_back(it);
                fetch_pc = fetch_pc + 32'd4;
                holding  = frz;
            end else if (!frz) begin
                holding = 1'b0;
            end
            if (upd) begin
                if (utk && bhtm[bidx(upc)] < 3) bhtm[bidx(upc)]++;
                if (!utk && bhtm[bidx(upc)] > 0) bhtm[bidx(upc)]--;
            end
        end
    endtask

    task automatic idle(input bit rdy, input bit frz);
        step(1'b0, rdy, frz, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic redirect(input logic [31:0] alt, input bit rdy, input bit frz);
        step(1'b0, rdy, frz, 1'b1, alt, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] upc, input bit utk);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, upc, utk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: compares the latch whenever it was due to load, otherwise checks it held
    initial begin : monitor
        logic        c_rst, c_frz, c_rdr, c_rdy;
        logic        p_req;
        logic [31:0] p_addr, p_instr, p_pc, p_pc4;
        logic        p_pred;
        item_t       e;
        p_req = 1'b0; p_addr = '0; p_instr = '0; p_pc = '0; p_pc4 = '0; p_pred = 1'b0;
        forever begin
            @(posedge CLK);
            c_rst = !RESET;
            c_frz = WANT_FREEZE_IN;
            c_rdr = Request_Alt_PC_IN;
            c_rdy = IMem_Ready_IN;
            #1;
            if (c_rst) begin
                check("rst_instr", Instr1_OUT, 32'h0);
                check("rst_pc", Instr1_PC_OUT, 32'h0);
                check("rst_pc4", Instr1_PC_Plus4_OUT, 32'h0);
                check("rst_pred", 32'(Branch_prediction_OUT), 32'h0);
                check("rst_req", 32'(IMem_Req_OUT), 32'h0);
                check("rst_addr", IMem_Addr_OUT, RESET_PC);
            end else begin
                if (p_req && !c_rdy) begin
                    check("req_held", 32'(IMem_Req_OUT), 32'h1);
                    check("addr_held", IMem_Addr_OUT, p_addr);
                end
                if (!c_frz || c_rdr) begin
                    if (Instr1_OUT == 32'h0) begin
                        check("bubble_pc", Instr1_PC_OUT, 32'h0);
                        check("bubble_pc4", Instr1_PC_Plus4_OUT, 32'h0);
                        check("bubble_pred", 32'(Branch_prediction_OUT), 32'h0);
                    end else if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr: got %h at pc %h expected bubble at %0t",
                                 Instr1_OUT, Instr1_PC_OUT, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr", Instr1_OUT, e.instr);
                        check("instr_pc", Instr1_PC_OUT, e.pc);
                        check("instr_pc4", Instr1_PC_Plus4_OUT, e.pc4);
                        check("pred", 32'(Branch_prediction_OUT), 32'(e.pred));
                    end
                end else begin
                    check("frz_instr", Instr1_OUT, p_instr);
                    check("frz_pc", Instr1_PC_OUT, p_pc);
                    check("frz_pc4", Instr1_PC_Plus4_OUT, p_pc4);
                    check("frz_pred", 32'(Branch_prediction_OUT), 32'(p_pred));
                end
            end
            p_req   = IMem_Req_OUT;
            p_addr  = IMem_Addr_OUT;
            p_instr = Instr1_OUT;
            p_pc    = Instr1_PC_OUT;
            p_pc4   = Instr1_PC_Plus4_OUT;
            p_pred  = Branch_prediction_OUT;
        end
    end

    // Stimulus: directed scenarios, then randomized traffic, then drain
    initial begin : stim
        bit          r_rst, r_rdy, r_frz, r_rdr, r_upd, r_tk;
        logic [31:0] r_alt, r_upc;
        int          sel;
        int          waited;
        RESET = 1'b0; IMem_Ready_IN = 1'b0; WANT_FREEZE_IN = 1'b0; Request_Alt_PC_IN = 1'b0;
        Alt_PC_IN = '0; BHT_Update_IN = 1'b0; BHT_Update_PC_IN = '0; BHT_Update_Taken_IN = 1'b0;
        model_reset();
        do_reset();
        do_reset();

        // streaming at full rate
        repeat (10) idle(1'b1, 1'b0);
        // memory stall for 3 cycles
        repeat (3) idle(1'b0, 1'b0);
        repeat (3) idle(1'b1, 1'b0);
        // ID freeze for 4 cycles while memory is ready
        repeat (4) idle(1'b1, 1'b1);
        repeat (4) idle(1'b1, 1'b0);
        // redirect with memory stalled, then redirect together with freeze
        redirect(32'h00400100, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        repeat (4) idle(1'b1, 1'b0);
        redirect(32'h00400040, 1'b0, 1'b1);
        repeat (4) idle(1'b1, 1'b0);

        // BHT training on 0x400008 followed by fetches that read it
        repeat (2) train(32'h00400008, 1'b1);
        redirect(32'h00400008, 1'b0, 1'b0);
        repeat (4) idle(1'b1, 1'b0);
        repeat (3) train(32'h00400008, 1'b0);
        redirect(32'h00400008, 1'b1, 1'b0);
        repeat (4) idle(1'b1, 1'b0);
        repeat (5) train(32'h00400008, 1'b1);
        redirect(32'h00400004, 1'b1, 1'b0);
        repeat (4) idle(1'b1, 1'b0);
        train(32'h00400008, 1'b0);
        redirect(32'h00400008, 1'b1, 1'b0);
        repeat (3) idle(1'b1, 1'b0);

        // reset while a word is parked in HOLD
        waited = 0;
        while (!holding && waited < 10) begin
            idle(1'b1, 1'b1);
            waited++;
        end
        check("hold_reached", 32'(holding), 32'h1);
        idle(1'b1, 1'b1);
        do_reset();
        repeat (5) idle(1'b1, 1'b0);

        // reset while draining a squashed request
        redirect(32'h00400200, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        do_reset();
        repeat (5) idle(1'b1, 1'b0);

        // wrap-around of the PC
        redirect(32'hFFFFFFF8, 1'b1, 1'b0);
        repeat (5) idle(1'b1, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom % 400) == 0;
            r_rdy = ($urandom % 10) < 7;
            r_frz = ($urandom % 10) < 2;
            r_rdr = ($urandom % 25) == 0;
            sel   = int'($urandom % 8);
            if (sel == 0)      r_alt = 32'hFFFFFFF8;
            else if (sel == 1) r_alt = RESET_PC + 32'($urandom_range(0, 63) * 4) + 32'($urandom % 4);
            else               r_alt = RESET_PC + 32'($urandom_range(0, 127) * 4);
            r_upd = ($urandom % 10) < 3;
            r_upc = RESET_PC + 32'($urandom_range(0, 63) * 4);
            r_tk  = ($urandom % 2) == 1;
            step(r_rst, r_rdy, r_frz, r_rdr, r_alt, r_upd, r_upc, r_tk);
        end

        // let every outstanding word reach the latch
        repeat (6) idle(1'b1, 1'b0);
        @(posedge CLK);
        #3;
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
